// File: rtl/mem_access_if.sv
// Request/response bundle between the core-side load/store path, mem_access_ctrl
// and the data memory.
interface mem_access_if;
  logic [31:0] addr;
  logic [31:0] wdata_in;
  logic        start;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata_out;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_we;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    input  addr, wdata_in, start, we, size, sign_ext, mem_ack, mem_rdata,
    output busy, done, err, rdata_out, mem_addr, mem_wdata, mem_be, mem_we, mem_req
  );

  modport slave (
    output addr, wdata_in, start, we, size, sign_ext, mem_ack, mem_rdata,
    input  busy, done, err, rdata_out, mem_addr, mem_wdata, mem_be, mem_we, mem_req
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store access controller: aligns the address, builds byte enables and
// replicated store data, runs the req/ack handshake with timeout, extends loads.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  mem_access_if.master bus
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         size_q, size_d;
  logic [1:0]         off_q, off_d;
  logic               sext_q, sext_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic               mwe_q, mwe_d;
  logic               req_q, req_d;

  logic               legal_c;
  logic [3:0]         be_c;
  logic [31:0]        wdata_c;
  logic [31:0]        lane_c;
  logic [31:0]        load_c;

  // Alignment check, byte enables and lane replication from the live request
  always_comb begin
    legal_c = 1'b0;
    be_c    = 4'b1111;
    wdata_c = bus.wdata_in;
    case (bus.size)
      2'b00: begin
        legal_c = 1'b1;
        be_c    = 4'b0001 << bus.addr[1:0];
        wdata_c = {4{bus.wdata_in[7:0]}};
      end
      2'b01: begin
        legal_c = ~bus.addr[0];
        be_c    = bus.addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{bus.wdata_in[15:0]}};
      end
      2'b10: legal_c = (bus.addr[1:0] == 2'b00);
      default: legal_c = 1'b0;
    endcase
  end

  // Load lane extraction and extension using the latched request attributes
  always_comb begin
    lane_c = bus.mem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'b00:   load_c = sext_q ? {{24{lane_c[7]}}, lane_c[7:0]} : {24'h0, lane_c[7:0]};
      2'b01:   load_c = sext_q ? {{16{lane_c[15]}}, lane_c[15:0]} : {16'h0, lane_c[15:0]};
      default: load_c = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    off_d   = off_q;
    sext_d  = sext_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    mwe_d   = mwe_q;
    req_d   = req_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          size_d = bus.size;
          off_d  = bus.addr[1:0];
          sext_d = bus.sign_ext;
          cnt_d  = '0;
          if (legal_c) begin
            state_d = REQ;
            req_d   = 1'b1;
            mwe_d   = bus.we;
            addr_d  = {bus.addr[31:2], 2'b00};
            be_d    = be_c;
            wdata_d = wdata_c;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
      end
      REQ: begin
        // An ack in the final timeout cycle still completes the transfer
        if (bus.mem_ack) begin
          state_d = DONE;
          done_d  = 1'b1;
          req_d   = 1'b0;
          mwe_d   = 1'b0;
          if (!mwe_q) rdata_d = load_c;
        end else if (cnt_q + CNT_W'(1) == CNT_W'(TIMEOUT)) begin
          state_d = ERR;
          err_d   = 1'b1;
          req_d   = 1'b0;
          mwe_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      size_q  <= '0;
      off_q   <= '0;
      sext_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      mwe_q   <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      off_q   <= off_d;
      sext_q  <= sext_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      mwe_q   <= mwe_d;
      req_q   <= req_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rdata_out = rdata_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_we    = mwe_q;
  assign bus.mem_req   = req_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: stores, loads, misalignment, timeout,
// async reset mid-transfer and ignored start/ack.
module tb_mem_access_ctrl;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   n;
  int   dones;

  mem_access_if bus();

  mem_access_ctrl #(.TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one active edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.we        = 1'b0;
    bus.size      = 2'b00;
    bus.sign_ext  = 1'b0;
    bus.addr      = 32'h0;
    bus.wdata_in  = 32'h0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz,
                       input logic w, input logic sx);
    bus.addr     = a;
    bus.wdata_in = wd;
    bus.size     = sz;
    bus.we       = w;
    bus.sign_ext = sx;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    idle_inputs();
    rst = 1'b1;
    repeat (2) tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    chk("rst_rdata", bus.rdata_out, 32'h0);
    chk("rst_done_err", 32'({bus.done, bus.err}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Word store, ack three cycles after start
    issue(32'h100, 32'hDEADBEEF, 2'b10, 1'b1, 1'b0);
    bus.addr = 32'hFFFF_FFFF;
    bus.wdata_in = 32'h0;
    chk("ws_req", 32'(bus.mem_req), 32'd1);
    chk("ws_busy", 32'(bus.busy), 32'd1);
    chk("ws_addr", bus.mem_addr, 32'h100);
    chk("ws_be", 32'(bus.mem_be), 32'hF);
    chk("ws_wdata", bus.mem_wdata, 32'hDEADBEEF);
    chk("ws_we", 32'(bus.mem_we), 32'd1);
    tick();
    tick();
    chk("ws_req_e2", 32'(bus.mem_req), 32'd1);
    chk("ws_addr_stable", bus.mem_addr, 32'h100);
    chk("ws_done_early", 32'(bus.done), 32'd0);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("ws_done", 32'(bus.done), 32'd1);
    chk("ws_req_drop", 32'(bus.mem_req), 32'd0);
    chk("ws_rdata_untouched", bus.rdata_out, 32'h0);
    tick();
    chk("ws_done_pulse", 32'(bus.done), 32'd0);
    chk("ws_busy_end", 32'(bus.busy), 32'd0);

    // Signed and unsigned byte load from lane 3
    issue(32'h203, 32'h0, 2'b00, 1'b0, 1'b1);
    chk("lb_be", 32'(bus.mem_be), 32'h8);
    chk("lb_addr", bus.mem_addr, 32'h200);
    chk("lb_we", 32'(bus.mem_we), 32'd0);
    bus.mem_rdata = 32'h80FF1234;
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("lb_done", 32'(bus.done), 32'd1);
    chk("lb_sext", bus.rdata_out, 32'hFFFFFF80);
    tick();
    issue(32'h203, 32'h0, 2'b00, 1'b0, 1'b0);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("lbu_zext", bus.rdata_out, 32'h00000080);
    tick();

    // Half store at offset 2, then signed half load from offset 2
    issue(32'h42, 32'h0000ABCD, 2'b01, 1'b1, 1'b0);
    chk("hs_addr", bus.mem_addr, 32'h40);
    chk("hs_be", 32'(bus.mem_be), 32'hC);
    chk("hs_wdata", bus.mem_wdata, 32'hABCDABCD);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("hs_done", 32'(bus.done), 32'd1);
    tick();
    issue(32'h42, 32'h0, 2'b01, 1'b0, 1'b1);
    bus.mem_rdata = 32'h80017FFF;
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("lh_sext", bus.rdata_out, 32'hFFFF8001);
    tick();

    // Misaligned half and illegal size produce a lone err pulse
    issue(32'h41, 32'h0, 2'b01, 1'b1, 1'b0);
    chk("mis_err", 32'(bus.err), 32'd1);
    chk("mis_req", 32'(bus.mem_req), 32'd0);
    chk("mis_rdata", bus.rdata_out, 32'hFFFF8001);
    tick();
    chk("mis_err_pulse", 32'(bus.err), 32'd0);
    chk("mis_busy_end", 32'(bus.busy), 32'd0);
    issue(32'h0, 32'h0, 2'b11, 1'b0, 1'b0);
    chk("ill_err", 32'(bus.err), 32'd1);
    chk("ill_req", 32'(bus.mem_req), 32'd0);
    tick();

    // Word load with no ack times out after 16 request cycles
    issue(32'h300, 32'h0, 2'b10, 1'b0, 1'b0);
    n = 0;
    dones = 0;
    while (bus.mem_req && n < 40) begin
      n++;
      if (bus.done) dones++;
      tick();
    end
    chk("to_req_cycles", 32'(n), 32'd16);
    chk("to_err", 32'(bus.err), 32'd1);
    chk("to_no_done", 32'(dones + int'(bus.done)), 32'd0);
    chk("to_rdata", bus.rdata_out, 32'hFFFF8001);
    tick();
    chk("to_err_pulse", 32'(bus.err), 32'd0);

    // Ack arriving in the 16th request cycle wins over the timeout
    issue(32'h300, 32'h0, 2'b10, 1'b0, 1'b0);
    repeat (15) tick();
    chk("tw_req_still", 32'(bus.mem_req), 32'd1);
    bus.mem_rdata = 32'h12345678;
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("tw_done", 32'(bus.done), 32'd1);
    chk("tw_no_err", 32'(bus.err), 32'd0);
    chk("tw_rdata", bus.rdata_out, 32'h12345678);
    tick();

    // Asynchronous reset two cycles into REQ
    issue(32'h400, 32'h0, 2'b10, 1'b0, 1'b0);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("ar_req", 32'(bus.mem_req), 32'd0);
    chk("ar_busy", 32'(bus.busy), 32'd0);
    chk("ar_done_err", 32'({bus.done, bus.err}), 32'd0);
    chk("ar_rdata", bus.rdata_out, 32'h0);
    #1;
    rst = 1'b0;
    tick();
    chk("ar_idle_after", 32'({bus.busy, bus.err, bus.done}), 32'd0);
    issue(32'h10, 32'h55AA55AA, 2'b10, 1'b1, 1'b0);
    chk("ar_fresh_req", 32'(bus.mem_req), 32'd1);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("ar_fresh_done", 32'(bus.done), 32'd1);
    tick();

    // start while busy is dropped; stray ack in IDLE does nothing
    issue(32'h20, 32'h0, 2'b10, 1'b0, 1'b0);
    dones = 0;
    bus.addr = 32'h24;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("sb_addr", bus.mem_addr, 32'h20);
    bus.mem_rdata = 32'hCAFEF00D;
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    if (bus.done) dones++;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.done) dones++;
    end
    chk("sb_one_done", 32'(dones), 32'd1);
    chk("sb_not_queued", 32'({bus.busy, bus.mem_req}), 32'd0);
    chk("sb_rdata", bus.rdata_out, 32'hCAFEF00D);
    bus.mem_rdata = 32'h11111111;
    bus.mem_ack = 1'b1;
    tick();
    tick();
    bus.mem_ack = 1'b0;
    chk("stray_ack_flags", 32'({bus.busy, bus.done, bus.err, bus.mem_req}), 32'd0);
    chk("stray_ack_rdata", bus.rdata_out, 32'hCAFEF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
